// File: rtl/npa_pkg.sv
// Shared types, defaults and the saturating-add helper for the AXI
// performance statistics stage (npa_axi_perf_stat).
package npa_pkg;

    localparam int NPA_LAT_WIDTH     = 16;
    localparam int NPA_WINDOW_CYCLES = 1024;
    localparam int NPA_OT_DEPTH      = 4;

    typedef logic [NPA_LAT_WIDTH-1:0] ts_t;

    // Saturating add on a counter of 'width' bits (width <= 64); the
    // caller truncates the result back to its own counter width.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/npa_ts_fifo.sv
// Timestamp FIFO for one AXI ID. Push while full and pop while empty are
// ignored here; the parent detects and counts those as errors.
module npa_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [AW:0]             cnt;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    // Storage, pointers and occupancy; pointers wrap at DEPTH-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            end
            if (do_pop)
                rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/npa_axi_perf_stat.sv
// Passive AXI statistics stage: windowed byte/transaction counts and
// read (optionally write) latency from per-ID timestamp FIFOs.
// Optional feature macro: NPA_WR_LAT_EN builds the write latency table;
// without it wr_lat_max is tied to 0 and AWID/BID are ignored.
// Full/empty for the overflow/orphan decisions are taken from the state at
// the start of the cycle, so a same-cycle pop never frees room for a push
// and a same-cycle push never feeds a pop. Latencies of 2^LAT_WIDTH cycles
// or more alias (timestamp wraps).
module npa_axi_perf_stat
    import npa_pkg::*;
#(
    parameter int ID_WIDTH      = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int WINDOW_CYCLES = NPA_WINDOW_CYCLES,
    parameter int CNT_WIDTH     = 32,
    parameter int LAT_WIDTH     = 16,
    parameter int OT_DEPTH      = NPA_OT_DEPTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [ID_WIDTH-1:0]     RID,
    input  logic                    RLAST,
    input  logic                    RVALID,
    input  logic                    RREADY,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic                    AWVALID,
    input  logic                    AWREADY,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    input  logic                    WREADY,
    input  logic [ID_WIDTH-1:0]     BID,
    input  logic                    BVALID,
    input  logic                    BREADY,
    output logic                    stat_valid,
    output logic [CNT_WIDTH-1:0]    rd_bytes,
    output logic [CNT_WIDTH-1:0]    wr_bytes,
    output logic [CNT_WIDTH-1:0]    rd_txn,
    output logic [CNT_WIDTH-1:0]    wr_txn,
    output logic [CNT_WIDTH-1:0]    rd_lat_sum,
    output logic [LAT_WIDTH-1:0]    rd_lat_max,
    output logic [LAT_WIDTH-1:0]    wr_lat_max,
    output logic [CNT_WIDTH-1:0]    err_cnt
);
    localparam int NID  = 1 << ID_WIDTH;
    localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [WC_W-1:0]      wcnt;
    logic [LAT_WIDTH-1:0] ts;
    logic                 win_end;

    logic ar_hs, r_last_hs, aw_hs, w_hs;

    assign ar_hs     = ARVALID & ARREADY;
    assign r_last_hs = RVALID & RREADY & RLAST;
    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign win_end   = (wcnt == WC_W'(WINDOW_CYCLES-1));

    // Window position and free-running timestamp
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wcnt <= '0;
            ts   <= '0;
        end else begin
            wcnt <= win_end ? '0 : wcnt + 1'b1;
            ts   <= ts + 1'b1;
        end
    end

    // ---------------- read latency table ----------------
    logic [NID-1:0]                rd_push, rd_pop, rd_full, rd_empty;
    logic [NID-1:0][LAT_WIDTH-1:0] rd_dout;
    logic                          rd_ovf, rd_orph, rd_lat_vld;
    logic [LAT_WIDTH-1:0]          rd_lat;

    for (genvar i = 0; i < NID; i++) begin : g_rd
        assign rd_push[i] = ar_hs & (ARID == ID_WIDTH'(i));
        assign rd_pop[i]  = r_last_hs & (RID == ID_WIDTH'(i));
        npa_ts_fifo #(.DEPTH(OT_DEPTH), .W(LAT_WIDTH)) u_fifo (
            .clk   (ACLK),
            .rst   (ARESET),
            .push  (rd_push[i]),
            .pop   (rd_pop[i]),
            .din   (ts),
            .dout  (rd_dout[i]),
            .full  (rd_full[i]),
            .empty (rd_empty[i])
        );
    end

    assign rd_ovf     = ar_hs & rd_full[ARID];
    assign rd_orph    = r_last_hs & rd_empty[RID];
    assign rd_lat_vld = r_last_hs & ~rd_empty[RID];
    assign rd_lat     = ts - rd_dout[RID];

    // ---------------- write latency table ----------------
    logic wr_ovf, wr_orph;

`ifdef NPA_WR_LAT_EN
    logic                          b_hs;
    logic [NID-1:0]                wr_push, wr_pop, wr_full, wr_empty;
    logic [NID-1:0][LAT_WIDTH-1:0] wr_dout;
    logic                          wr_lat_vld;
    logic [LAT_WIDTH-1:0]          wr_lat;
    logic [LAT_WIDTH-1:0]          acc_wr_lat_max, nxt_wr_lat_max;

    assign b_hs = BVALID & BREADY;

    for (genvar i = 0; i < NID; i++) begin : g_wr
        assign wr_push[i] = aw_hs & (AWID == ID_WIDTH'(i));
        assign wr_pop[i]  = b_hs & (BID == ID_WIDTH'(i));
        npa_ts_fifo #(.DEPTH(OT_DEPTH), .W(LAT_WIDTH)) u_fifo (
            .clk   (ACLK),
            .rst   (ARESET),
            .push  (wr_push[i]),
            .pop   (wr_pop[i]),
            .din   (ts),
            .dout  (wr_dout[i]),
            .full  (wr_full[i]),
            .empty (wr_empty[i])
        );
    end

    assign wr_ovf         = aw_hs & wr_full[AWID];
    assign wr_orph        = b_hs & wr_empty[BID];
    assign wr_lat_vld     = b_hs & ~wr_empty[BID];
    assign wr_lat         = ts - wr_dout[BID];
    assign nxt_wr_lat_max = (wr_lat_vld && wr_lat > acc_wr_lat_max) ? wr_lat : acc_wr_lat_max;

    // Windowed write latency maximum and its snapshot
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            acc_wr_lat_max <= '0;
            wr_lat_max     <= '0;
        end else if (win_end) begin
            acc_wr_lat_max <= '0;
            wr_lat_max     <= nxt_wr_lat_max;
        end else begin
            acc_wr_lat_max <= nxt_wr_lat_max;
        end
    end
`else
    logic unused_wr_sigs;
    assign unused_wr_sigs = ^{AWID, BID, BVALID, BREADY};
    assign wr_ovf         = 1'b0;
    assign wr_orph        = 1'b0;
    assign wr_lat_max     = '0;
`endif

    // ---------------- window accumulators ----------------
    logic [CNT_WIDTH-1:0] acc_rd_bytes, acc_wr_bytes, acc_rd_txn, acc_wr_txn;
    logic [CNT_WIDTH-1:0] acc_lat_sum, acc_err;
    logic [LAT_WIDTH-1:0] acc_rd_lat_max;
    logic [CNT_WIDTH-1:0] nxt_rd_bytes, nxt_wr_bytes, nxt_rd_txn, nxt_wr_txn;
    logic [CNT_WIDTH-1:0] nxt_lat_sum, nxt_err;
    logic [LAT_WIDTH-1:0] nxt_rd_lat_max;
    logic [63:0]          rd_bytes_inc, wr_bytes_inc, lat_inc, err_inc;

    // Next accumulator values including this cycle's events
    always_comb begin
        rd_bytes_inc = ar_hs ? ((64'(ARLEN) + 64'd1) << ARSIZE) : 64'd0;
        wr_bytes_inc = w_hs ? 64'($countones(WSTRB)) : 64'd0;
        lat_inc      = rd_lat_vld ? 64'(rd_lat) : 64'd0;
        err_inc      = 64'(rd_ovf) + 64'(rd_orph) + 64'(wr_ovf) + 64'(wr_orph);

        nxt_rd_bytes   = CNT_WIDTH'(sat_add(64'(acc_rd_bytes), rd_bytes_inc, CNT_WIDTH));
        nxt_wr_bytes   = CNT_WIDTH'(sat_add(64'(acc_wr_bytes), wr_bytes_inc, CNT_WIDTH));
        nxt_rd_txn     = CNT_WIDTH'(sat_add(64'(acc_rd_txn), 64'(ar_hs), CNT_WIDTH));
        nxt_wr_txn     = CNT_WIDTH'(sat_add(64'(acc_wr_txn), 64'(aw_hs), CNT_WIDTH));
        nxt_lat_sum    = CNT_WIDTH'(sat_add(64'(acc_lat_sum), lat_inc, CNT_WIDTH));
        nxt_err        = CNT_WIDTH'(sat_add(64'(acc_err), err_inc, CNT_WIDTH));
        nxt_rd_lat_max = (rd_lat_vld && rd_lat > acc_rd_lat_max) ? rd_lat : acc_rd_lat_max;
    end

    // Accumulate; at window end snapshot to outputs and restart from zero
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            acc_rd_bytes   <= '0;
            acc_wr_bytes   <= '0;
            acc_rd_txn     <= '0;
            acc_wr_txn     <= '0;
            acc_lat_sum    <= '0;
            acc_err        <= '0;
            acc_rd_lat_max <= '0;
            stat_valid     <= 1'b0;
            rd_bytes       <= '0;
            wr_bytes       <= '0;
            rd_txn         <= '0;
            wr_txn         <= '0;
            rd_lat_sum     <= '0;
            rd_lat_max     <= '0;
            err_cnt        <= '0;
        end else begin
            stat_valid <= win_end;
            if (win_end) begin
                acc_rd_bytes   <= '0;
                acc_wr_bytes   <= '0;
                acc_rd_txn     <= '0;
                acc_wr_txn     <= '0;
                acc_lat_sum    <= '0;
                acc_err        <= '0;
                acc_rd_lat_max <= '0;
                rd_bytes       <= nxt_rd_bytes;
                wr_bytes       <= nxt_wr_bytes;
                rd_txn         <= nxt_rd_txn;
                wr_txn         <= nxt_wr_txn;
                rd_lat_sum     <= nxt_lat_sum;
                rd_lat_max     <= nxt_rd_lat_max;
                err_cnt        <= nxt_err;
            end else begin
                acc_rd_bytes   <= nxt_rd_bytes;
                acc_wr_bytes   <= nxt_wr_bytes;
                acc_rd_txn     <= nxt_rd_txn;
                acc_wr_txn     <= nxt_wr_txn;
                acc_lat_sum    <= nxt_lat_sum;
                acc_err        <= nxt_err;
                acc_rd_lat_max <= nxt_rd_lat_max;
            end
        end
    end

endmodule

// File: tb/tb_npa_axi_perf_stat.sv
// Bench for npa_axi_perf_stat: directed scenarios plus random traffic, all
// checked against a transaction-level model (per-ID queues of accept cycles).
module tb_npa_axi_perf_stat;
    localparam int IDW  = 4;
    localparam int DW   = 64;
    localparam int WIN  = 64;
    localparam int CW   = 12;
    localparam int LW   = 8;
    localparam int OTD  = 4;
    localparam longint CMAX  = (64'd1 << CW) - 1;
    localparam int     LMASK = (1 << LW) - 1;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [IDW-1:0] ARID, RID, AWID, BID;
    logic [7:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic           ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic           AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [DW/8-1:0] WSTRB;
    logic           stat_valid;
    logic [CW-1:0]  rd_bytes, wr_bytes, rd_txn, wr_txn, rd_lat_sum, err_cnt;
    logic [LW-1:0]  rd_lat_max, wr_lat_max;

    npa_axi_perf_stat #(
        .ID_WIDTH(IDW), .DATA_WIDTH(DW), .WINDOW_CYCLES(WIN),
        .CNT_WIDTH(CW), .LAT_WIDTH(LW), .OT_DEPTH(OTD)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
        .stat_valid(stat_valid), .rd_bytes(rd_bytes), .wr_bytes(wr_bytes),
        .rd_txn(rd_txn), .wr_txn(wr_txn), .rd_lat_sum(rd_lat_sum),
        .rd_lat_max(rd_lat_max), .wr_lat_max(wr_lat_max), .err_cnt(err_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    int     cyc;
    int     rq[16][$];
    int     wq[16][$];
    longint m_rb, m_wb, m_rt, m_wt, m_sum, m_err;
    int     m_rmax, m_wmax;

    function automatic longint sat(longint a, longint b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic set_idle();
        ARID = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 0; ARREADY = 0;
        RID = '0; RLAST = 0; RVALID = 0; RREADY = 0;
        AWID = '0; AWVALID = 0; AWREADY = 0;
        WSTRB = '0; WVALID = 0; WREADY = 0;
        BID = '0; BVALID = 0; BREADY = 0;
    endtask

    task automatic model_clear();
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            rq[i].delete();
            wq[i].delete();
        end
        m_rb = 0; m_wb = 0; m_rt = 0; m_wt = 0; m_sum = 0; m_err = 0;
        m_rmax = 0; m_wmax = 0;
    endtask

    // Apply the current inputs for one cycle, update the model, check after the edge.
    task automatic step();
        bit     sv;
        bit     ar_full, r_empty;
        int     lat;
        longint e_rb, e_wb, e_rt, e_wt, e_sum, e_err;
        int     e_rmax, e_wmax;
        sv = 0;
        e_rb = 0; e_wb = 0; e_rt = 0; e_wt = 0; e_sum = 0; e_err = 0; e_rmax = 0; e_wmax = 0;
        ar_full = (rq[ARID].size() >= OTD);
        r_empty = (rq[RID].size() == 0);
        if (RVALID && RREADY && RLAST) begin
            if (r_empty) m_err = sat(m_err, 1);
            else begin
                lat = (cyc - rq[RID].pop_front()) & LMASK;
                m_sum = sat(m_sum, lat);
                if (lat > m_rmax) m_rmax = lat;
            end
        end
        if (ARVALID && ARREADY) begin
            m_rt = sat(m_rt, 1);
            m_rb = sat(m_rb, (longint'(ARLEN) + 1) << ARSIZE);
            if (ar_full) m_err = sat(m_err, 1);
            else rq[ARID].push_back(cyc);
        end
        if (WVALID && WREADY) m_wb = sat(m_wb, $countones(WSTRB));
        if (AWVALID && AWREADY) m_wt = sat(m_wt, 1);
`ifdef NPA_WR_LAT_EN
        begin
            bit aw_full, b_empty;
            aw_full = (wq[AWID].size() >= OTD);
            b_empty = (wq[BID].size() == 0);
            if (BVALID && BREADY) begin
                if (b_empty) m_err = sat(m_err, 1);
                else begin
                    lat = (cyc - wq[BID].pop_front()) & LMASK;
                    if (lat > m_wmax) m_wmax = lat;
                end
            end
            if (AWVALID && AWREADY) begin
                if (aw_full) m_err = sat(m_err, 1);
                else wq[AWID].push_back(cyc);
            end
        end
`endif
        if (cyc % WIN == WIN - 1) begin
            sv = 1;
            e_rb = m_rb; e_wb = m_wb; e_rt = m_rt; e_wt = m_wt;
            e_sum = m_sum; e_err = m_err; e_rmax = m_rmax; e_wmax = m_wmax;
            m_rb = 0; m_wb = 0; m_rt = 0; m_wt = 0; m_sum = 0; m_err = 0;
            m_rmax = 0; m_wmax = 0;
        end
        @(posedge ACLK); #1;
        chk("stat_valid", {63'd0, stat_valid}, {63'd0, sv});
        if (sv) begin
            chk("rd_bytes", 64'(rd_bytes), e_rb);
            chk("wr_bytes", 64'(wr_bytes), e_wb);
            chk("rd_txn", 64'(rd_txn), e_rt);
            chk("wr_txn", 64'(wr_txn), e_wt);
            chk("rd_lat_sum", 64'(rd_lat_sum), e_sum);
            chk("rd_lat_max", 64'(rd_lat_max), 64'(e_rmax));
            chk("wr_lat_max", 64'(wr_lat_max), 64'(e_wmax));
            chk("err_cnt", 64'(err_cnt), e_err);
        end
        cyc++;
        set_idle();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        set_idle();
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_stat_valid", {63'd0, stat_valid}, 64'd0);
        chk("rst_rd_bytes", 64'(rd_bytes), 64'd0);
        chk("rst_wr_bytes", 64'(wr_bytes), 64'd0);
        chk("rst_rd_txn", 64'(rd_txn), 64'd0);
        chk("rst_wr_txn", 64'(wr_txn), 64'd0);
        chk("rst_lat_sum", 64'(rd_lat_sum), 64'd0);
        chk("rst_rd_lat_max", 64'(rd_lat_max), 64'd0);
        chk("rst_wr_lat_max", 64'(wr_lat_max), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        ARESET = 1'b0;
        model_clear();
    endtask

    task automatic ar(input int id, input int len, input int sz);
        ARVALID = 1; ARREADY = 1; ARID = IDW'(id); ARLEN = 8'(len); ARSIZE = 3'(sz);
    endtask

    task automatic rlast(input int id);
        RVALID = 1; RREADY = 1; RLAST = 1; RID = IDW'(id);
    endtask

    initial begin
        bit big;
        ARESET = 1'b1;
        set_idle();
        model_clear();
        do_reset();

        // Window 0: single read, write latency, W strobes
        run_to(5);  AWVALID = 1; AWREADY = 1; AWID = 4'd2; step();
        run_to(10); ar(3, 3, 3); step();
        run_to(12); BVALID = 1; BREADY = 1; BID = 4'd2; step();
        run_to(25); rlast(3); step();
        run_to(30);
        WVALID = 1; WREADY = 1; WSTRB = 8'hFF; step();
        WVALID = 1; WREADY = 1; WSTRB = 8'h0F; step();
        WVALID = 1; WREADY = 1; WSTRB = 8'h01; step();
        run_to(WIN);
        chk("tp_rd_bytes", 64'(rd_bytes), 64'd32);
        chk("tp_rd_txn", 64'(rd_txn), 64'd1);
        chk("tp_lat_sum", 64'(rd_lat_sum), 64'd15);
        chk("tp_lat_max", 64'(rd_lat_max), 64'd15);
        chk("tp_err", 64'(err_cnt), 64'd0);
        chk("tp_wr_bytes", 64'(wr_bytes), 64'd13);
`ifdef NPA_WR_LAT_EN
        chk("tp_wr_lat_max", 64'(wr_lat_max), 64'd7);
`else
        chk("tp_wr_lat_max", 64'(wr_lat_max), 64'd0);
`endif

        // Window 1: table overflow then orphan on ID 1
        for (int k = 0; k < 5; k++) begin
            run_to(WIN + 6 + k); ar(1, 0, 0); step();
        end
        for (int k = 0; k < 5; k++) begin
            run_to(WIN + 16 + k); rlast(1); step();
        end
        run_to(2 * WIN);
        chk("ovf_err", 64'(err_cnt), 64'd2);
        chk("ovf_rd_txn", 64'(rd_txn), 64'd5);

        // Window boundary: last cycle of window 2 vs first cycle of window 3
        run_to(3 * WIN - 1); ar(5, 0, 2); step();
        ar(5, 1, 2); step();
        chk("bnd_pulse_width", {63'd0, stat_valid}, 64'd0);
        chk("bnd_rd_bytes_n", 64'(rd_bytes), 64'd4);
        chk("bnd_rd_txn_n", 64'(rd_txn), 64'd1);
        run_to(4 * WIN);
        chk("bnd_rd_bytes_n1", 64'(rd_bytes), 64'd8);

        // Reset with three reads outstanding; later RLAST is an orphan
        run_to(4 * WIN + 4);
        ar(6, 0, 0); step();
        ar(6, 0, 0); step();
        ar(6, 0, 0); step();
        do_reset();
        run_to(3); rlast(6); step();
        run_to(WIN);
        chk("rst_orphan_err", 64'(err_cnt), 64'd1);
        chk("rst_orphan_sum", 64'(rd_lat_sum), 64'd0);

        // Random traffic; a few windows use huge bursts to force saturation
        while (cyc < 22 * WIN) begin
            big = (cyc / WIN >= 10 && cyc / WIN < 13);
            ARVALID = ($urandom % 3 == 0); ARREADY = ($urandom % 4 != 0);
            ARID = IDW'($urandom % 4);
            ARLEN = big ? 8'($urandom % 256) : 8'($urandom % 16);
            ARSIZE = big ? 3'($urandom % 8) : 3'($urandom % 4);
            RVALID = ($urandom % 3 == 0); RREADY = ($urandom % 4 != 0);
            RLAST = ($urandom % 2 == 0); RID = IDW'($urandom % 4);
            AWVALID = ($urandom % 3 == 0); AWREADY = ($urandom % 4 != 0);
            AWID = IDW'($urandom % 4);
            WVALID = ($urandom % 2 == 0); WREADY = ($urandom % 4 != 0);
            WSTRB = 8'($urandom);
            BVALID = ($urandom % 3 == 0); BREADY = ($urandom % 4 != 0);
            BID = IDW'($urandom % 4);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/npa_axi_perf_stat.md
Name: npa_axi_perf_stat

Overview:
- Passive per-interface AXI statistics stage.
- Taps the same AXI handshake signals a bus monitor observes and reduces them in hardware to windowed bandwidth, transaction and latency figures.
- Consumes nothing but handshakes and never drives the bus.
- Its snapshot outputs feed the NoC perf-analyzer report/CSR path.

Parameters:
ID_WIDTH, 4, AXI ID width; the latency table has 2^ID_WIDTH entries
DATA_WIDTH, 64, AXI data width; sets WSTRB width to DATA_WIDTH/8
WINDOW_CYCLES, 1024, snapshot window length in ACLK cycles, must be >=2
CNT_WIDTH, 32, width of byte/txn/sum counters
LAT_WIDTH, 16, timestamp and latency width
OT_DEPTH, 4, outstanding reads (and writes) tracked per ID, power of 2

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
ARID  in  ID_WIDTH  AR channel ID
ARLEN  in  8  AR burst length-1
ARSIZE  in  3  AR beat size log2 bytes
ARVALID  in  1  AR valid
ARREADY  in  1  AR ready
RID  in  ID_WIDTH  R channel ID
RLAST  in  1  R last beat
RVALID  in  1  R valid
RREADY  in  1  R ready
AWID  in  ID_WIDTH  AW channel ID
AWVALID  in  1  AW valid
AWREADY  in  1  AW ready
WSTRB  in  DATA_WIDTH/8  W byte strobes
WVALID  in  1  W valid
WREADY  in  1  W ready
BID  in  ID_WIDTH  B channel ID
BVALID  in  1  B valid
BREADY  in  1  B ready
stat_valid  out  1  one-cycle pulse: snapshot outputs updated
rd_bytes  out  CNT_WIDTH  read bytes requested in window
wr_bytes  out  CNT_WIDTH  write bytes strobed in window
rd_txn  out  CNT_WIDTH  AR handshakes in window
wr_txn  out  CNT_WIDTH  AW handshakes in window
rd_lat_sum  out  CNT_WIDTH  sum of completed read latencies
rd_lat_max  out  LAT_WIDTH  max read latency
wr_lat_max  out  LAT_WIDTH  max write latency (0 when feature off)
err_cnt  out  CNT_WIDTH  table overflows plus orphan completions

Behaviour:
- Reset: all outputs, accumulators, window counter, timestamp and tables are cleared to 0.
- Handshake: an event counts only in a cycle where VALID&READY.
- Window counter runs 0..WINDOW_CYCLES-1.
  - In the cycle it equals WINDOW_CYCLES-1, the accumulators including that cycle's events are copied to the outputs, and stat_valid=1 in the next cycle.
  - All accumulators are cleared at the same time.
  - Events in the first cycle of the new window go only into the new window.
- rd_bytes += (ARLEN+1)<<ARSIZE on each AR handshake.
- wr_bytes += popcount(WSTRB) on each W handshake.
- All CNT_WIDTH accumulators saturate at all-ones and do not wrap.
- Timestamp: free-running LAT_WIDTH counter that wraps.
- Read latency:
  - An AR handshake pushes the timestamp into per-ID FIFO[ARID].
  - An R handshake with RLAST pops FIFO[RID].
  - latency = (ts_now - ts_pushed) mod 2^LAT_WIDTH, i.e. cycles from AR accept to last-beat accept. Back-to-back AR then RLAST in the next cycle gives 1.
  - On pop: rd_lat_sum += latency and rd_lat_max is updated.
  - Push and pop on the same ID in the same cycle is legal. If the FIFO is empty, the push is not visible to the same-cycle pop, so it counts as an orphan.
- Full FIFO on push: the push is dropped, err_cnt += 1 and the occupancy is unchanged.
- RLAST pop on an empty FIFO (orphan): err_cnt += 1 and no latency is recorded.
- Both error events in one cycle add 2.
- Latencies of 2^LAT_WIDTH cycles or more alias; this limit is documented.

Optional Feature:
NPA_WR_LAT_EN
- Defined: a second per-ID FIFO bank is built.
  - An AW handshake pushes; a B handshake pops FIFO[BID].
  - wr_lat_max is tracked with the same overflow and orphan rules, both feeding err_cnt.
- Undefined: AWID and BID are ignored, no write table is built, and wr_lat_max is tied to 0.

Decomposition:
- npa_pkg holds:
  - typedef ts_t (logic [LAT_WIDTH-1:0]);
  - constants for the default WINDOW_CYCLES and OT_DEPTH;
  - function sat_add(acc, inc).
- Sub-module npa_ts_fifo: depth-OT_DEPTH timestamp FIFO with push, pop, full, empty and dout. The read and write tables each instantiate 2^ID_WIDTH copies.

Test Plan:
- Single AR (ID 3, ARLEN 3, ARSIZE 3) at cycle 10, RLAST at cycle 25 -> window snapshot: rd_bytes=32, rd_txn=1, rd_lat_sum=15, rd_lat_max=15, err_cnt=0.
- 5 ARs on ID 1 with no R (OT_DEPTH 4) -> err_cnt=1; 4 RLASTs then 1 extra RLAST -> err_cnt=2.
- W beats with WSTRB 0xFF, 0x0F, 0x01 -> wr_bytes=13.
- Event on cycle WINDOW_CYCLES-1 and another on cycle 0 of the next window -> first lands in snapshot N, second in snapshot N+1, stat_valid pulse one cycle wide.
- ARESET asserted with 3 reads outstanding, then RLAST after release -> outputs 0 during reset, the RLAST counts as an orphan (err_cnt=1).
- NPA_WR_LAT_EN: AW ID 2 at cycle 5, B ID 2 at cycle 12 -> wr_lat_max=7. Without the macro, wr_lat_max=0.
